// File: rtl/trigger_window_pkg.sv
// Shared types and default widths for the acquisition window gate.
package trigger_window_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
    localparam int unsigned DEFAULT_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACQUIRE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/trigger_window_gate_if.sv
// ADC input stream and gated output stream toward the RAM writer.
interface trigger_window_gate_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/trigger_window_gate_rising_edge_detector.sv
// Registers the input and flags cycles where it is 1 now and was 0 last cycle.
module rising_edge_detector (
    input  logic clk,
    input  logic aresetn,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) sig_q <= 1'b0;
        else          sig_q <= sig;
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/trigger_window_gate.sv
// Trigger-started acquisition window between ADC stream and RAM writer.
// Optional TRIGGER_WINDOW_TIMESTAMP_EN adds a 64-bit window start timestamp.
module trigger_window_gate
    import trigger_window_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   trigger,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] window_length,
    trigger_window_gate_if.slave   axis,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] sample_count,
    output logic                   overflow
`ifdef TRIGGER_WINDOW_TIMESTAMP_EN
    ,
    output logic [63:0]            window_timestamp
`endif
);

    state_t                 state, state_next;
    logic                   trig_edge;
    logic                   arm, start, accept;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] count_plus;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q;

    rising_edge_detector u_edge (
        .clk     (clk),
        .aresetn (aresetn),
        .sig     (trigger),
        .pulse   (trig_edge)
    );

    assign count_plus = sample_count + 1'b1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        arm        = 1'b0;
        start      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = WAIT;
                    arm        = 1'b1;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (trig_edge) begin
                    state_next = ACQUIRE;
                    start      = 1'b1;
                end
            end
            ACQUIRE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (axis.s_axis_tvalid) begin
                    accept = 1'b1;
                    if (len_q != '0 && count_plus == len_q) state_next = DONE;
                end
            end
            DONE: begin
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Samples are counted even when dropped: the window length is a time span.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sample_count <= '0;
            overflow     <= 1'b0;
            len_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            if (arm) begin
                sample_count <= '0;
                overflow     <= 1'b0;
            end
            if (start) len_q <= window_length;
            if (accept) begin
                sample_count <= count_plus;
                if (!valid_q || axis.m_axis_tready) begin
                    data_q  <= axis.s_axis_tdata;
                    valid_q <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid_q && axis.m_axis_tready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef TRIGGER_WINDOW_TIMESTAMP_EN
    logic [63:0] sample_clock;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sample_clock     <= '0;
            window_timestamp <= '0;
        end else begin
            if (axis.s_axis_tvalid) sample_clock <= sample_clock + 64'd1;
            if (start)              window_timestamp <= sample_clock;
        end
    end
`endif

    assign busy               = (state == ACQUIRE);
    assign done               = (state == DONE);
    assign axis.m_axis_tdata  = data_q;
    assign axis.m_axis_tvalid = valid_q;

endmodule

// File: tb/tb_trigger_window_gate.sv
// Directed bench for trigger_window_gate: per-cycle vector table plus window sequences.
module tb_trigger_window_gate;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        trigger = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] window_length = '0;
    logic        busy, done, overflow;
    logic [31:0] sample_count;
`ifdef TRIGGER_WINDOW_TIMESTAMP_EN
    logic [63:0] window_timestamp;
`endif

    trigger_window_gate_if #(.DATA_WIDTH(32)) axis ();

    trigger_window_gate #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .trigger       (trigger),
        .enable        (enable),
        .window_length (window_length),
        .axis          (axis),
        .busy          (busy),
        .done          (done),
        .sample_count  (sample_count),
        .overflow      (overflow)
`ifdef TRIGGER_WINDOW_TIMESTAMP_EN
        ,
        .window_timestamp (window_timestamp)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic        en, trg;
        logic [31:0] len;
        logic        sv;
        logic [31:0] sd;
        logic        rdy;
        logic        busy, done;
        logic [31:0] cnt;
        logic        mv;
        logic [31:0] md;
        logic        ovf;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rearm();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("rearm_cnt", sample_count, 0);
        check("rearm_ovf", overflow, 0);
        check("rearm_done", done, 0);
    endtask

    // Trigger edge at j=0; sample j carries 0x100+j; handshakes are recorded in got_q.
    task automatic run_window(input int every, input int lo, input int hi, input int maxc,
                              output int done_at);
        logic rdy;
        done_at = -1;
        got_q.delete();
        trigger = 1'b0;
        axis.s_axis_tvalid = 1'b0;
        axis.m_axis_tready = 1'b1;
        step();
        trigger = 1'b1;
        axis.s_axis_tdata = 32'h100;
        step();
        for (int j = 1; j <= maxc; j++) begin
            rdy = !(j >= lo && j <= hi);
            axis.s_axis_tvalid = ((j - 1) % every) == 0;
            axis.s_axis_tdata  = 32'h100 + j;
            axis.m_axis_tready = rdy;
            if (axis.m_axis_tvalid && rdy) got_q.push_back(axis.m_axis_tdata);
            step();
            if (done && done_at < 0) done_at = j;
        end
        axis.s_axis_tvalid = 1'b0;
    endtask

    task automatic cmp_queues(input string name);
        check({name, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({name, "_data"}, got_q[i], exp_q[i]);
    endtask

    initial begin
        int d;
        axis.s_axis_tdata  = '0;
        axis.s_axis_tvalid = 1'b0;
        axis.m_axis_tready = 1'b0;

        //            en trg len    sv sd            rdy busy done cnt mv md            ovf
        tbl[0]  = '{1'b0, 1'b0, 4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[2]  = '{1'b1, 1'b1, 4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, 1'b1, 4, 1'b1, 32'hA0000000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000001, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'hA0000001, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000002, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'hA0000001, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1, 1'b0, 32'hDEAD0000, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'hA0000001, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000003, 1'b1, 1'b1, 1'b0, 3, 1'b1, 32'hA0000003, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000004, 1'b1, 1'b0, 1'b1, 4, 1'b1, 32'hA0000004, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000005, 1'b0, 1'b0, 1'b1, 4, 1'b1, 32'hA0000004, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1, 1'b1, 32'hA0000006, 1'b1, 1'b0, 1'b1, 4, 1'b0, 32'hA0000004, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 4, 1'b0, 32'hA0000004, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 2, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 0, 1'b0, 32'hA0000004, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_cnt", sample_count, 0);
        check("reset_mvalid", axis.m_axis_tvalid, 0);
        check("reset_mdata", axis.m_axis_tdata, 0);
        check("reset_ovf", overflow, 0);
        aresetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            enable             = tbl[i].en;
            trigger            = tbl[i].trg;
            window_length      = tbl[i].len;
            axis.s_axis_tvalid = tbl[i].sv;
            axis.s_axis_tdata  = tbl[i].sd;
            axis.m_axis_tready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("vec%0d_done", i), done, tbl[i].done);
            check($sformatf("vec%0d_cnt", i), sample_count, tbl[i].cnt);
            check($sformatf("vec%0d_mvalid", i), axis.m_axis_tvalid, tbl[i].mv);
            check($sformatf("vec%0d_mdata", i), axis.m_axis_tdata, tbl[i].md);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
        end

        // Length 8, continuous samples, no stalls.
        rearm();
        window_length = 8;
        run_window(1, 99, 0, 20, d);
        exp_q.delete();
        for (int k = 1; k <= 8; k++) exp_q.push_back(32'h100 + k);
        cmp_queues("len8");
        check("len8_done_at", d, 8);
        check("len8_done", done, 1);
        check("len8_busy", busy, 0);
        check("len8_cnt", sample_count, 8);
        check("len8_ovf", overflow, 0);

        // Length 10, valid every other cycle.
        rearm();
        window_length = 10;
        run_window(2, 99, 0, 30, d);
        exp_q.delete();
        for (int k = 0; k < 10; k++) exp_q.push_back(32'h101 + 2 * k);
        cmp_queues("len10");
        check("len10_done_at", d, 19);
        check("len10_cnt", sample_count, 10);

        // Length 6 with tready low on cycles 2..4: samples 2..4 dropped.
        rearm();
        window_length = 6;
        run_window(1, 2, 4, 15, d);
        exp_q.delete();
        exp_q.push_back(32'h101);
        exp_q.push_back(32'h105);
        exp_q.push_back(32'h106);
        cmp_queues("stall");
        check("stall_done_at", d, 6);
        check("stall_cnt", sample_count, 6);
        check("stall_ovf", overflow, 1);

        // Abort after 4 of 100 samples, then re-arm.
        rearm();
        window_length = 100;
        run_window(1, 99, 0, 4, d);
        check("abort_pre_busy", busy, 1);
        enable = 1'b0;
        axis.s_axis_tvalid = 1'b1;
        step();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_cnt", sample_count, 4);
        axis.s_axis_tvalid = 1'b0;
        rearm();

        // Reset pulse while a sample is pending.
        window_length = 50;
        run_window(1, 99, 0, 3, d);
        check("prerst_mvalid", axis.m_axis_tvalid, 1);
        axis.s_axis_tvalid = 1'b0;
        trigger = 1'b0;
        enable  = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", sample_count, 0);
        check("rst_mvalid", axis.m_axis_tvalid, 0);
        check("rst_mdata", axis.m_axis_tdata, 0);
        check("rst_ovf", overflow, 0);
        step();
        aresetn = 1'b1;

`ifdef TRIGGER_WINDOW_TIMESTAMP_EN
        check("ts_reset", window_timestamp, 0);
        axis.s_axis_tvalid = 1'b1;
        repeat (37) step();
        axis.s_axis_tvalid = 1'b0;
        enable = 1'b1;
        step();
        trigger = 1'b1;
        step();
        check("ts_busy", busy, 1);
        check("ts_value", window_timestamp, 37);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
